// File: rtl/game_display_driver_pkg.sv
// Shared types and constants for the game status / display-holder block.
package game_display_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    OVER    = 2'd2
  } state_t;

  localparam logic [3:0] HEX_BLANK = 4'hF;
  localparam logic [9:0] LED_OVER  = 10'b1010101010;

  // Binary 0..99 to packed two-digit BCD {tens, ones}.
  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/game_display_driver_bcd2_counter.sv
// Two-digit BCD counter: load, saturating increment (99) and decrement (00).
// Exposes the next value so the parent can register its outputs from it.
module bcd2_counter #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] q_nxt
);

  logic [3:0] tens, ones;
  logic       zero, full;

  assign zero = ({tens, ones} == 8'h00);
  assign full = ({tens, ones} == 8'h99);

  always_comb begin
    q_nxt = {tens, ones};
    if (load)
      q_nxt = load_val;
    else if (inc && !full)
      q_nxt = (ones == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, ones + 4'd1};
    else if (dec && !zero)
      q_nxt = (ones == 4'd0) ? {tens - 4'd1, 4'd9} : {tens, ones - 4'd1};
  end

  always_ff @(posedge clk) begin
    if (reset) {tens, ones} <= RST_VAL;
    else       {tens, ones} <= q_nxt;
  end

endmodule

// File: rtl/game_display_driver.sv
// Game-status sequencer feeding the seven-segment/LEDR stage with digit holders.
// Optional miss limit enabled by defining MISS_LIMIT_EN.
module game_display_driver
  import game_display_driver_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECS    = 60,
  parameter int FLASH_CYCLES = 12_500_000,
  parameter int MISS_LIMIT   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_game,
  input  logic       userquit,
  input  logic       match_pulse,
  input  logic       miss_pulse,
  input  logic [3:0] mode,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex2hldr,
  output logic [3:0] hex3hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  localparam int         PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int         FW       = $clog2(FLASH_CYCLES + 1);
  localparam logic [7:0] GAME_BCD = to_bcd2(GAME_SECS);

  state_t          state, state_nxt;
  logic [PW-1:0]   prescaler;
  logic [FW-1:0]   flash, flash_nxt;
  logic [7:0]      timer_nxt, score_nxt;
  logic            playing, tick, load, miss_over;
  logic [2:0]      miss_led;

  assign playing = (state == PLAYING);
  assign tick    = playing && (prescaler == PW'(CLK_HZ - 1));

  bcd2_counter #(.RST_VAL(GAME_BCD)) u_timer (
    .clk(CLOCK_50), .reset(reset), .load(load), .load_val(GAME_BCD),
    .inc(1'b0), .dec(tick && !userquit), .q_nxt(timer_nxt)
  );

  bcd2_counter #(.RST_VAL(8'h00)) u_score (
    .clk(CLOCK_50), .reset(reset), .load(load), .load_val(8'h00),
    .inc(playing && match_pulse && !userquit), .dec(1'b0), .q_nxt(score_nxt)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (userquit)
      state_nxt = IDLE;
    else begin
      case (state)
        IDLE, OVER: if (start_game) begin
          state_nxt = PLAYING;
          load      = 1'b1;
        end
        PLAYING: if ((tick && timer_nxt == 8'h00) || miss_over) state_nxt = OVER;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Flash only survives while staying in PLAYING; leaving cancels it.
  always_comb begin
    flash_nxt = '0;
    if (state_nxt == PLAYING) begin
      if (playing && match_pulse) flash_nxt = FW'(FLASH_CYCLES);
      else if (flash != '0)       flash_nxt = flash - FW'(1);
    end
  end

`ifdef MISS_LIMIT_EN
  localparam logic [1:0] MISS_LIM = 2'(MISS_LIMIT);
  logic [1:0] miss_cnt, miss_nxt;

  always_comb begin
    miss_nxt = miss_cnt;
    if (load)
      miss_nxt = 2'd0;
    else if (playing && miss_pulse && miss_cnt != 2'd3)
      miss_nxt = miss_cnt + 2'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) miss_cnt <= 2'd0;
    else       miss_cnt <= miss_nxt;
  end

  assign miss_over = playing && (miss_cnt >= MISS_LIM);
  assign miss_led  = {miss_nxt >= 2'd1, miss_nxt >= 2'd2, miss_nxt == 2'd3};
`else
  logic unused_miss;
  assign unused_miss = miss_pulse & (MISS_LIMIT != 0);
  assign miss_over   = 1'b0;
  assign miss_led    = 3'b000;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescaler <= '0;
      flash     <= '0;
    end else begin
      prescaler <= (!playing || tick) ? '0 : prescaler + PW'(1);
      flash     <= flash_nxt;
    end
  end

  // Outputs are registered from next-state values so events show one cycle later.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      ingameOn <= 1'b0;
      gameOver <= 1'b0;
      hex0hldr <= 4'h0;
      hex2hldr <= HEX_BLANK;
      hex3hldr <= HEX_BLANK;
      hex4hldr <= HEX_BLANK;
      hex5hldr <= HEX_BLANK;
      ledrhldr <= '0;
    end else begin
      state    <= state_nxt;
      ingameOn <= (state_nxt == PLAYING);
      gameOver <= (state_nxt == OVER);
      hex0hldr <= mode;
      hex2hldr <= HEX_BLANK;
      hex3hldr <= HEX_BLANK;
      hex4hldr <= HEX_BLANK;
      hex5hldr <= HEX_BLANK;
      ledrhldr <= '0;
      case (state_nxt)
        PLAYING: begin
          {hex3hldr, hex2hldr} <= timer_nxt;
          {hex5hldr, hex4hldr} <= score_nxt;
          ledrhldr <= (flash_nxt != '0) ? 10'h3FF : {miss_led, 7'd0};
        end
        OVER: begin
          {hex5hldr, hex4hldr} <= score_nxt;
          ledrhldr <= LED_OVER;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_display_driver.sv
// Bench for game_display_driver: vector table, corner sequences, random vs model.
module tb_game_display_driver;

  localparam int HZ    = 4;
  localparam int SECS  = 3;
  localparam int FLASH = 2;
`ifdef MISS_LIMIT_EN
  localparam int MLIM  = 3;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, start_game = 1'b0, userquit = 1'b0;
  logic       match_pulse = 1'b0, miss_pulse = 1'b0;
  logic [3:0] mode = 4'd0;
  logic       ingameOn, gameOver;
  logic [3:0] hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr;
  logic [9:0] ledrhldr;
  logic       o99_ingame, o99_over;
  logic [3:0] o99_h0, o99_h2, o99_h3, o99_h4, o99_h5;
  logic [9:0] o99_led;
  logic [31:0] bundle;

  int n_pass = 0, n_total = 0;

  // Model state: plain integers, seconds and score in binary.
  bit         m_play, m_over;
  int         m_secs, m_score, m_sub, m_flash, m_miss;
  logic [3:0] m_mode;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_display_driver #(.CLK_HZ(HZ), .GAME_SECS(SECS), .FLASH_CYCLES(FLASH), .MISS_LIMIT(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game), .userquit(userquit),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse), .mode(mode),
    .ingameOn(ingameOn), .gameOver(gameOver), .hex0hldr(hex0hldr), .hex2hldr(hex2hldr),
    .hex3hldr(hex3hldr), .hex4hldr(hex4hldr), .hex5hldr(hex5hldr), .ledrhldr(ledrhldr)
  );

  game_display_driver #(.CLK_HZ(HZ), .GAME_SECS(99), .FLASH_CYCLES(FLASH), .MISS_LIMIT(3)) dut99 (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game), .userquit(userquit),
    .match_pulse(match_pulse), .miss_pulse(miss_pulse), .mode(mode),
    .ingameOn(o99_ingame), .gameOver(o99_over), .hex0hldr(o99_h0), .hex2hldr(o99_h2),
    .hex3hldr(o99_h3), .hex4hldr(o99_h4), .hex5hldr(o99_h5), .ledrhldr(o99_led)
  );

  assign bundle = {ingameOn, gameOver, hex0hldr, hex5hldr, hex4hldr, hex3hldr, hex2hldr, ledrhldr};

  typedef struct {
    logic s, q, m; logic [3:0] md; int cyc;
    logic ig, go; logic [3:0] h3, h2, h5, h4; logic [9:0] led;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_play = 0; m_over = 0; m_secs = SECS; m_score = 0;
    m_sub = 0; m_flash = 0; m_miss = 0; m_mode = 4'd0;
  endtask

  task automatic model_step(input bit s, input bit q, input bit m, input bit x, input logic [3:0] md);
    bit ended;
    m_mode = md;
    if (q) begin
      m_play = 0; m_over = 0; m_flash = 0;
      return;
    end
    if (m_play) begin
      ended = 0;
      if (m && m_score < 99) m_score++;
      m_flash = m ? FLASH : ((m_flash > 0) ? m_flash - 1 : 0);
`ifdef MISS_LIMIT_EN
      if (m_miss >= MLIM) ended = 1;
`endif
      if (x && m_miss < 3) m_miss++;
      m_sub++;
      if (m_sub == HZ) begin
        m_sub = 0;
        m_secs--;
        if (m_secs == 0) ended = 1;
      end
      if (ended) begin m_play = 0; m_over = 1; m_flash = 0; end
    end else if (s) begin
      m_play = 1; m_over = 0; m_secs = SECS; m_score = 0;
      m_sub = 0; m_miss = 0; m_flash = 0;
    end
  endtask

  function automatic logic [31:0] model_out();
    logic [3:0] h2, h3, h4, h5;
    logic [9:0] led;
    h2 = 4'hF; h3 = 4'hF; h4 = 4'hF; h5 = 4'hF; led = '0;
    if (m_play || m_over) begin
      h5 = 4'(m_score / 10);
      h4 = 4'(m_score % 10);
    end
    if (m_play) begin
      h3 = 4'(m_secs / 10);
      h2 = 4'(m_secs % 10);
      if (m_flash > 0) led = 10'h3FF;
`ifdef MISS_LIMIT_EN
      else for (int i = 0; i < m_miss; i++) led[9-i] = 1'b1;
`endif
    end else if (m_over) led = 10'b1010101010;
    return {m_play, m_over, m_mode, h5, h4, h3, h2, led};
  endfunction

  task automatic step(input bit s, input bit q, input bit m, input bit x, input logic [3:0] md);
    start_game = s; userquit = q; match_pulse = m; miss_pulse = x; mode = md;
    @(posedge CLOCK_50);
    model_step(s, q, m, x, md);
    @(negedge CLOCK_50);
    start_game = 0; userquit = 0; match_pulse = 0; miss_pulse = 0;
  endtask

  task automatic do_reset();
    reset = 1; mode = 4'd7;
    start_game = 0; userquit = 0; match_pulse = 0; miss_pulse = 0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset", bundle, {2'b00, 4'h0, 16'hFFFF, 10'h000});
    reset = 0;
    model_reset();
  endtask

  initial begin
    //         s  q  m  md    cyc ig go h3    h2    h5    h4    led
    tbl[0]  = '{0, 0, 0, 4'd5, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h000};
    tbl[1]  = '{1, 0, 0, 4'd5, 1, 1, 0, 4'h0, 4'h3, 4'h0, 4'h0, 10'h000};
    tbl[2]  = '{0, 0, 1, 4'd6, 1, 1, 0, 4'h0, 4'h3, 4'h0, 4'h1, 10'h3FF};
    tbl[3]  = '{0, 0, 0, 4'd6, 2, 1, 0, 4'h0, 4'h3, 4'h0, 4'h1, 10'h000};
    tbl[4]  = '{0, 0, 0, 4'd6, 1, 1, 0, 4'h0, 4'h2, 4'h0, 4'h1, 10'h000};
    tbl[5]  = '{0, 0, 0, 4'd7, 8, 0, 1, 4'hF, 4'hF, 4'h0, 4'h1, 10'h2AA};
    tbl[6]  = '{0, 0, 1, 4'd7, 1, 0, 1, 4'hF, 4'hF, 4'h0, 4'h1, 10'h2AA};
    tbl[7]  = '{1, 0, 0, 4'd8, 1, 1, 0, 4'h0, 4'h3, 4'h0, 4'h0, 10'h000};
    tbl[8]  = '{0, 1, 0, 4'd8, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h000};
    tbl[9]  = '{1, 1, 0, 4'd9, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h000};
    tbl[10] = '{1, 0, 0, 4'd9, 1, 1, 0, 4'h0, 4'h3, 4'h0, 4'h0, 10'h000};
    tbl[11] = '{1, 0, 0, 4'd9, 1, 1, 0, 4'h0, 4'h3, 4'h0, 4'h0, 10'h000};
    tbl[12] = '{0, 1, 0, 4'd0, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 10'h000};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].s, tbl[i].q, tbl[i].m, 1'b0, tbl[i].md);
      for (int k = 1; k < tbl[i].cyc; k++) step(0, 0, 0, 0, tbl[i].md);
      check($sformatf("vec%0d", i), bundle,
            {tbl[i].ig, tbl[i].go, tbl[i].md, tbl[i].h5, tbl[i].h4, tbl[i].h3, tbl[i].h2, tbl[i].led});
    end

    // Score roll-over and saturation (second instance has a 99 s game).
    step(1, 0, 0, 0, 4'd0);
    repeat (10) step(0, 0, 1, 0, 4'd0);
    check("score_roll", 32'({hex5hldr, hex4hldr}), 32'h10);
    repeat (89) step(0, 0, 1, 0, 4'd0);
    check("score_99", 32'({o99_h5, o99_h4}), 32'h99);
    repeat (6) step(0, 0, 1, 0, 4'd0);
    check("score_sat", 32'({o99_ingame, o99_h5, o99_h4}), 32'h199);
    step(0, 1, 0, 0, 4'd0);

    // Back-to-back matches restart the flash.
    step(1, 0, 0, 0, 4'd0);
    step(0, 0, 1, 0, 4'd0); check("flash_a", 32'(ledrhldr), 32'h3FF);
    step(0, 0, 1, 0, 4'd0); check("flash_b", 32'(ledrhldr), 32'h3FF);
    step(0, 0, 0, 0, 4'd0); check("flash_c", 32'(ledrhldr), 32'h3FF);
    step(0, 0, 0, 0, 4'd0); check("flash_d", 32'(ledrhldr), 32'h000);
    step(0, 1, 0, 0, 4'd0);

    // Match lands on the final tick.
    step(1, 0, 0, 0, 4'd0);
    repeat (11) step(0, 0, 0, 0, 4'd0);
    check("pre_final", 32'({ingameOn, hex3hldr, hex2hldr}), 32'h101);
    step(0, 0, 1, 0, 4'd0);
    check("final_race", 32'({gameOver, hex5hldr, hex4hldr, ledrhldr}), {13'd0, 1'b1, 8'h01, 10'h2AA});
    step(1, 0, 0, 0, 4'd0);
    check("restart", 32'({ingameOn, hex3hldr, hex2hldr, hex5hldr, hex4hldr}), 32'h10300);
    step(0, 1, 0, 0, 4'd0);

    // Misses: lit LEDs and game end only with the miss limit enabled.
    step(1, 0, 0, 0, 4'd0);
`ifdef MISS_LIMIT_EN
    step(0, 0, 0, 1, 4'd0); check("miss1", 32'(ledrhldr), 32'h200);
    step(0, 0, 0, 1, 4'd0); check("miss2", 32'(ledrhldr), 32'h300);
    step(0, 0, 0, 1, 4'd0); check("miss3", 32'({ingameOn, ledrhldr}), 32'h780);
    step(0, 0, 0, 0, 4'd0); check("miss_end", 32'({ingameOn, gameOver, ledrhldr}), 32'h6AA);
`else
    step(0, 0, 0, 1, 4'd0); check("miss1", 32'(ledrhldr), 32'h000);
    step(0, 0, 0, 1, 4'd0); check("miss2", 32'(ledrhldr), 32'h000);
    step(0, 0, 0, 1, 4'd0); check("miss3", 32'({ingameOn, ledrhldr}), 32'h400);
    step(0, 0, 0, 0, 4'd0); check("miss_end", 32'({ingameOn, gameOver, ledrhldr}), 32'h800);
`endif
    step(0, 1, 0, 0, 4'd0);

    // Random stimulus against the behavioural model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)));
      check($sformatf("rand%0d", n), bundle, model_out());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
